// File: rtl/dmem_responder_if.sv
// Request/response bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_w_en;
  logic [2:0]  req_funct3;
  logic [31:0] req_w_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_r_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_w_en, req_funct3, req_w_data, resp_ready,
    input  req_ready, resp_valid, resp_r_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_w_en, req_funct3, req_w_data, resp_ready,
    output req_ready, resp_valid, resp_r_data, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering RV32I loads/stores over a valid/ready bus.
// One request in flight: IDLE accepts, ACCESS touches the RAM, RESP holds the answer.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic [1:0]      lane_q;
  logic            w_en_q;
  logic [2:0]      funct3_q;
  logic [31:0]     w_data_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            accept;
  logic [31:0]     offs;
  logic            range_err, align_err, code_err, err_d;
  logic [31:0]     rd_word, rd_shift, load_val;
  logic [15:0]     rd_half;
  logic [3:0]      wmask;
  logic [31:0]     wdata;

  assign accept = bus.req_valid && bus.req_ready;
  assign offs   = bus.req_addr - ADDR_BASE;

  // Request classification, evaluated on the incoming bus so the error is latched at acceptance.
  always_comb begin
    range_err = (bus.req_addr < ADDR_BASE) || ({2'b00, offs[31:2]} >= DEPTH_WORDS);
    align_err = ((bus.req_funct3[1:0] == 2'b01) && offs[0]) ||
                ((bus.req_funct3[1:0] == 2'b10) && (offs[1:0] != 2'b00));
    if (bus.req_w_en) begin
      code_err = (bus.req_funct3 > 3'b010);
    end else begin
      code_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                 (bus.req_funct3 == 3'b111);
    end
    err_d = range_err || align_err || code_err;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state_q == S_IDLE);
    bus.resp_valid  = (state_q == S_RESP);
    bus.resp_r_data = rdata_q;
    bus.resp_err    = err_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      lane_q   <= '0;
      w_en_q   <= 1'b0;
      funct3_q <= '0;
      w_data_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      idx_q    <= offs[AW+1:2];
      lane_q   <= offs[1:0];
      w_en_q   <= bus.req_w_en;
      funct3_q <= bus.req_funct3;
      w_data_q <= bus.req_w_data;
      err_q    <= err_d;
      rdata_q  <= '0;
    end else if (state_q == S_ACCESS) begin
      rdata_q  <= (err_q || w_en_q) ? '0 : load_val;
    end
  end

  assign rd_word  = mem_q[idx_q];
  assign rd_shift = rd_word >> {lane_q, 3'b000};
  assign rd_half  = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_val = {24'h0, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'h0, rd_half};
      3'b010:  load_val = rd_word;
      default: load_val = '0;
    endcase
  end

  // Store data is replicated across lanes so the byte mask alone selects what lands.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wmask = 4'b0001 << lane_q;
        wdata = {4{w_data_q[7:0]}};
      end
      2'b01: begin
        wmask = 4'b0011 << lane_q;
        wdata = {2{w_data_q[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = w_data_q;
      end
    endcase
  end

  // RAM is not reset; an async reset before the ACCESS edge leaves state_q != ACCESS, so no write.
  always_ff @(posedge clock) begin
    if ((state_q == S_ACCESS) && !err_q && w_en_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask[b]) mem_q[idx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded random/directed bench for dmem_responder against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic clock;
  logic reset_n;
  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  int          ready_mode = 0;
  exp_t        sb[$];
  logic [7:0]  ref_mem [4*DEPTH];
  bit          in_resp    = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, result derived from access size and sign rule.
  function automatic void model(input logic [31:0] a, input bit we, input logic [2:0] f3,
                                input logic [31:0] wd, output logic err, output logic [31:0] data);
    logic [31:0] off;
    int unsigned sz;
    bit bad;
    off  = a - BASE;
    sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    err  = bad || (a < BASE) || (off >= 4*DEPTH) || ((off % sz) != 0);
    data = '0;
    if (!err) begin
      if (we) begin
        for (int unsigned i = 0; i < sz; i++) ref_mem[off+i] = wd[8*i +: 8];
      end else begin
        for (int unsigned i = 0; i < sz; i++) data[8*i +: 8] = ref_mem[off+i];
        if (!f3[2] && sz < 4 && data[8*sz-1]) begin
          for (int unsigned i = sz; i < 4; i++) data[8*i +: 8] = 8'hFF;
        end
      end
    end
  endfunction

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       bus.resp_ready = 1'b1;
      1:       bus.resp_ready = 1'b0;
      default: bus.resp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      in_resp = 1'b0;
    end else if (bus.resp_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response pending");
      end else begin
        if (!in_resp) begin
          in_resp = 1'b1;
          chk("resp_latency", 32'(cyc), 32'(sb[0].acc + 1));
        end
        if (bus.resp_ready) begin
          chk("resp_err", {31'b0, bus.resp_err}, {31'b0, sb[0].err});
          chk("resp_r_data", bus.resp_r_data, sb[0].data);
          void'(sb.pop_front());
          in_resp = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [31:0] a, input bit we, input logic [2:0] f3,
                       input logic [31:0] wd, input bit abort = 1'b0);
    exp_t e;
    int   budget;
    bus.req_addr   = a;
    bus.req_w_en   = we;
    bus.req_funct3 = f3;
    bus.req_w_data = wd;
    bus.req_valid  = 1'b1;
    budget = 0;
    while (!bus.req_ready && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!bus.req_ready) begin
      chk("req_accept_timeout", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (!abort) begin
      model(a, we, f3, wd, e.err, e.data);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    if (abort) reset_n = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((sb.size() != 0 || !bus.req_ready) && budget < 300) begin
      @(negedge clock);
      budget++;
    end
    if (sb.size() != 0 || !bus.req_ready) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    repeat (2) @(negedge clock);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_resp_r_data", bus.resp_r_data, 32'd0);
    sb.delete();
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_w_en   = 1'b0;
    bus.req_funct3 = '0;
    bus.req_w_data = '0;
    bus.resp_ready = 1'b1;
    #1;
    chk("por_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("por_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("por_resp_r_data", bus.resp_r_data, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("por_req_ready", {31'b0, bus.req_ready}, 32'd1);

    for (int unsigned w = 0; w < 64; w++) issue(BASE + 4*w, 1'b1, 3'b010, $urandom);
    for (int unsigned w = DEPTH-4; w < DEPTH; w++) issue(BASE + 4*w, 1'b1, 3'b010, $urandom);

    issue(32'h10, 1'b1, 3'b010, 32'hDEADBEEF);
    issue(32'h10, 1'b0, 3'b010, 32'h0);

    issue(32'h20, 1'b1, 3'b010, 32'h0);
    issue(32'h21, 1'b1, 3'b000, 32'h0000_0080);
    issue(32'h20, 1'b0, 3'b010, 32'h0);
    issue(32'h21, 1'b0, 3'b000, 32'h0);
    issue(32'h21, 1'b0, 3'b100, 32'h0);
    issue(32'h22, 1'b1, 3'b001, 32'h0000_8001);
    issue(32'h22, 1'b0, 3'b001, 32'h0);
    issue(32'h22, 1'b0, 3'b101, 32'h0);

    issue(32'h12, 1'b0, 3'b010, 32'h0);
    issue(32'h13, 1'b1, 3'b001, 32'hFFFF_FFFF);
    issue(32'h10, 1'b0, 3'b011, 32'h0);
    issue(32'h10, 1'b1, 3'b011, 32'h5555_5555);
    issue(32'h10, 1'b0, 3'b010, 32'h0);

    issue(BASE + 4*DEPTH, 1'b0, 3'b010, 32'h0);
    issue(BASE + 4*(DEPTH-1), 1'b0, 3'b010, 32'h0);
    drain();

    ready_mode = 1;
    @(negedge clock);
    issue(32'h10, 1'b0, 3'b010, 32'h0);
    bus.req_addr   = 32'h14;
    bus.req_w_en   = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_w_data = 32'hBAD0_BAD0;
    bus.req_valid  = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("bp_resp_r_data", bus.resp_r_data, 32'hDEADBEEF);
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    ready_mode = 0;
    drain();
    issue(32'h14, 1'b0, 3'b010, 32'h0);
    drain();

    ready_mode = 1;
    @(negedge clock);
    issue(32'h10, 1'b0, 3'b010, 32'h0);
    @(negedge clock);
    chk("rst_pre_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
    reset_n = 1'b0;
    ready_mode = 0;
    pulse_reset();

    issue(32'h10, 1'b1, 3'b010, 32'h1234_5678, 1'b1);
    pulse_reset();
    issue(32'h10, 1'b0, 3'b010, 32'h0);
    drain();

    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 14)      a = BASE + $urandom_range(0, 255);
      else if (r < 17) a = BASE + 4*(DEPTH-4) + $urandom_range(0, 15);
      else if (r < 19) a = BASE + 4*DEPTH + $urandom_range(0, 64);
      else             a = $urandom | 32'h8000_0000;
      issue(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
